mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter for the Nova core. It shares a single memory bus between the instruction-fetch path (read-only) and the data load/store path. Each side uses a req/ack handshake. The arbiter latches the winning request, drives the memory bus until the memory acknowledges or a timeout fires, then returns registered read data and an ack pulse to the requester. Ties alternate between the two ports, so neither can starve the other.

---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory bus between the instruction-fetch port (read-only) and
// the data load/store port. A three-state FSM (IDLE -> BUSY -> DONE) latches
// the winning request, holds it on the memory bus until mem_ack or a timeout,
// then pulses the owner's ack for one cycle with registered read data.
// Simultaneous requests alternate between the ports using last_grant.
//
// Parameters:
//   TIMEOUT    max BUSY cycles without mem_ack before abort (0 = never)
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   i_req/i_addr                fetch request and byte address
//   i_rdata/i_ack/i_err         fetch read data, ack pulse, timeout flag
//   d_req/d_we/d_addr/          data request, store strobe, byte address,
//   d_wdata/d_be                store data and byte enables
//   d_rdata/d_ack/d_err         data read data, ack pulse, timeout flag
//   mem_req/mem_we/mem_addr/    memory bus request and latched fields
//   mem_wdata/mem_be
//   mem_rdata/mem_ack           memory read data and completion
//   busy                        high in BUSY and DONE
//   grant_d                     current/last owner (1 = data, 0 = fetch)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        grant_d
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] count_reg;
    logic        last_grant_reg;
    logic        grant_d_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [3:0]  mem_be_reg;
    logic [31:0] i_rdata_reg;
    logic [31:0] d_rdata_reg;
    logic        i_ack_reg;
    logic        d_ack_reg;
    logic        i_err_reg;
    logic        d_err_reg;
    logic        busy_reg;

    // Data wins when it is the only requester, or on a tie when fetch was
    // the last owner.
    logic pick_d;
    logic any_req;
    logic timeout_hit;

    always_comb begin
        pick_d      = d_req && (!i_req || !last_grant_reg);
        any_req     = i_req || d_req;
        timeout_hit = (TIMEOUT != 16'd0) && (count_reg == (TIMEOUT - 16'd1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= 16'd0;
            last_grant_reg <= 1'b0;
            grant_d_reg    <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_wdata_reg  <= 32'd0;
            mem_be_reg     <= 4'd0;
            i_rdata_reg    <= 32'd0;
            d_rdata_reg    <= 32'd0;
            i_ack_reg      <= 1'b0;
            d_ack_reg      <= 1'b0;
            i_err_reg      <= 1'b0;
            d_err_reg      <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_d_reg <= pick_d;
                        count_reg   <= 16'd0;
                        mem_req_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= BUSY;
                        if (pick_d) begin
                            mem_we_reg    <= d_we;
                            mem_addr_reg  <= d_addr;
                            mem_wdata_reg <= d_wdata;
                            mem_be_reg    <= d_be;
                        end else begin
                            mem_we_reg    <= 1'b0;
                            mem_addr_reg  <= i_addr;
                            mem_wdata_reg <= 32'd0;
                            mem_be_reg    <= 4'hF;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= DONE;
                        // Stores also load rdata; the value is don't-care.
                        if (grant_d_reg) begin
                            d_rdata_reg <= mem_rdata;
                            d_ack_reg   <= 1'b1;
                        end else begin
                            i_rdata_reg <= mem_rdata;
                            i_ack_reg   <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= DONE;
                        if (grant_d_reg) begin
                            d_ack_reg <= 1'b1;
                            d_err_reg <= 1'b1;
                        end else begin
                            i_ack_reg <= 1'b1;
                            i_err_reg <= 1'b1;
                        end
                    end else if (count_reg != 16'hFFFF) begin
                        count_reg <= count_reg + 16'd1;
                    end
                end
                DONE: begin
                    i_ack_reg      <= 1'b0;
                    d_ack_reg      <= 1'b0;
                    i_err_reg      <= 1'b0;
                    d_err_reg      <= 1'b0;
                    busy_reg       <= 1'b0;
                    last_grant_reg <= grant_d_reg;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata   = i_rdata_reg;
    assign i_ack     = i_ack_reg;
    assign i_err     = i_err_reg;
    assign d_rdata   = d_rdata_reg;
    assign d_ack     = d_ack_reg;
    assign d_err     = d_err_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_be    = mem_be_reg;
    assign busy      = busy_reg;
    assign grant_d   = grant_d_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Table-driven bench for mem_arbiter (TIMEOUT = 4). Each table record is one
// transaction: request inputs, memory wait cycles and response data, and the
// hand-computed bus fields, owner, BUSY length, err flag and read data.
// Hand-written sequences cover mem_ack while idle and reset mid-transaction.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int NEVER = 99;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        grant_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(16'd4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .busy(busy), .grant_d(grant_d)
    );

    typedef struct {
        logic        rst;
        logic        i_req;
        logic        d_req;
        logic        d_we;
        logic        keep;
        logic [31:0] i_addr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        int          waits;
        logic [31:0] rdata;
        logic        exp_g;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic        exp_err;
        int          exp_busy_n;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(
        input logic rst, input logic ir, input logic dr, input logic we,
        input logic keep, input logic [31:0] ia, input logic [31:0] da,
        input logic [31:0] dwd, input logic [3:0] dbe, input int waits,
        input logic [31:0] rdata, input logic eg, input logic [31:0] ea,
        input logic ewe, input logic [31:0] ewd, input logic [3:0] ebe,
        input logic eerr, input int en, input logic [31:0] erd);
        vec_t v;
        v.rst = rst; v.i_req = ir; v.d_req = dr; v.d_we = we; v.keep = keep;
        v.i_addr = ia; v.d_addr = da; v.d_wdata = dwd; v.d_be = dbe;
        v.waits = waits; v.rdata = rdata; v.exp_g = eg; v.exp_addr = ea;
        v.exp_we = ewe; v.exp_wdata = ewd; v.exp_be = ebe; v.exp_err = eerr;
        v.exp_busy_n = en; v.exp_rdata = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int nb;
        string p;
        p = $sformatf("v%0d", idx);
        if (v.rst) begin
            i_req = 1'b0;
            d_req = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
        end
        i_req = v.i_req;  d_req = v.d_req;  d_we = v.d_we;
        i_addr = v.i_addr; d_addr = v.d_addr; d_wdata = v.d_wdata; d_be = v.d_be;
        mem_ack = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_req && lat < 8);
        chk({p, " req_latency"}, lat, 1);
        nb = 0;
        while (mem_req && nb < 30) begin
            chk({p, " mem_addr"}, mem_addr, v.exp_addr);
            chk({p, " mem_we"}, {31'd0, mem_we}, {31'd0, v.exp_we});
            chk({p, " mem_wdata"}, mem_wdata, v.exp_wdata);
            chk({p, " mem_be"}, {28'd0, mem_be}, {28'd0, v.exp_be});
            chk({p, " grant_d"}, {31'd0, grant_d}, {31'd0, v.exp_g});
            chk({p, " busy_in_busy"}, {31'd0, busy}, 32'd1);
            chk({p, " early_ack"}, {30'd0, i_ack, d_ack}, 32'd0);
            nb++;
            if (nb == v.waits + 1) begin
                mem_ack = 1'b1;
                mem_rdata = v.rdata;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk({p, " busy_cycles"}, nb, v.exp_busy_n);
        chk({p, " i_ack"}, {31'd0, i_ack}, {31'd0, !v.exp_g});
        chk({p, " d_ack"}, {31'd0, d_ack}, {31'd0, v.exp_g});
        if (v.exp_g) begin
            chk({p, " d_err"}, {31'd0, d_err}, {31'd0, v.exp_err});
            chk({p, " d_rdata"}, d_rdata, v.exp_rdata);
            chk({p, " i_err"}, {31'd0, i_err}, 32'd0);
        end else begin
            chk({p, " i_err"}, {31'd0, i_err}, {31'd0, v.exp_err});
            chk({p, " i_rdata"}, i_rdata, v.exp_rdata);
            chk({p, " d_err"}, {31'd0, d_err}, 32'd0);
        end
        chk({p, " busy_in_done"}, {31'd0, busy}, 32'd1);
        if (!v.keep) begin
            if (v.exp_g) d_req = 1'b0;
            else         i_req = 1'b0;
        end
        @(negedge clk);
        chk({p, " ack_one_cycle"}, {30'd0, i_ack, d_ack}, 32'd0);
        chk({p, " idle_busy"}, {31'd0, busy}, 32'd0);
        chk({p, " idle_mem_req"}, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        //              rst ir dr we kp i_addr        d_addr        d_wdata       be    waits  rdata         g  exp_addr      we exp_wdata     be    err n  exp_rdata
        vecs[0] = mk(0, 1, 0, 0, 0, 32'h0000_0100, 32'h0,        32'h0,        4'h0, 0,     32'hDEAD_BEEF, 0, 32'h0000_0100, 0, 32'h0,        4'hF, 0, 1, 32'hDEAD_BEEF);
        vecs[1] = mk(0, 0, 1, 1, 0, 32'h0,        32'h0000_2000, 32'h1234_5678, 4'h3, 3,     32'hA5A5_A5A5, 1, 32'h0000_2000, 1, 32'h1234_5678, 4'h3, 0, 4, 32'hA5A5_A5A5);
        vecs[2] = mk(0, 0, 1, 0, 0, 32'h0,        32'h0000_3000, 32'h0,        4'hF, NEVER, 32'hCAFE_F00D, 1, 32'h0000_3000, 0, 32'h0,        4'hF, 1, 4, 32'hA5A5_A5A5);
        vecs[3] = mk(0, 0, 1, 0, 0, 32'h0,        32'h0000_3004, 32'h0,        4'hF, 1,     32'h0BAD_F00D, 1, 32'h0000_3004, 0, 32'h0,        4'hF, 0, 2, 32'h0BAD_F00D);
        vecs[4] = mk(1, 1, 1, 0, 0, 32'h0000_0400, 32'h0000_0500, 32'h1111_1111, 4'h5, 0,     32'h5000_0001, 1, 32'h0000_0500, 0, 32'h1111_1111, 4'h5, 0, 1, 32'h5000_0001);
        vecs[5] = mk(0, 1, 1, 0, 0, 32'h0000_0400, 32'h0000_0500, 32'h1111_1111, 4'h5, 2,     32'h4000_0001, 0, 32'h0000_0400, 0, 32'h0,        4'hF, 0, 3, 32'h4000_0001);
        vecs[6] = mk(0, 1, 1, 0, 0, 32'h0000_0400, 32'h0000_0500, 32'h1111_1111, 4'h5, 0,     32'h5000_0002, 1, 32'h0000_0500, 0, 32'h1111_1111, 4'h5, 0, 1, 32'h5000_0002);
        vecs[7] = mk(0, 1, 1, 0, 0, 32'h0000_0400, 32'h0000_0500, 32'h1111_1111, 4'h5, 0,     32'h4000_0002, 0, 32'h0000_0400, 0, 32'h0,        4'hF, 0, 1, 32'h4000_0002);
        vecs[8] = mk(0, 1, 0, 0, 1, 32'h0000_0104, 32'h0,        32'h0,        4'h0, 0,     32'h7777_7777, 0, 32'h0000_0104, 0, 32'h0,        4'hF, 0, 1, 32'h7777_7777);
        vecs[9] = mk(0, 1, 0, 0, 0, 32'h0000_0108, 32'h0,        32'h0,        4'h0, 1,     32'h8888_8888, 0, 32'h0000_0108, 0, 32'h0,        4'hF, 0, 2, 32'h8888_8888);

        reset = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst acks_errs", {28'd0, i_ack, d_ack, i_err, d_err}, 32'd0);
        chk("rst busy_grant", {30'd0, busy, grant_d}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst i_rdata", i_rdata, 32'd0);
        chk("rst d_rdata", d_rdata, 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 10; k++) begin
            run_vec(k, vecs[k]);
        end
        i_req = 1'b0;
        d_req = 1'b0;

        // mem_ack while idle must be ignored
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_ack busy", {31'd0, busy}, 32'd0);
            chk("idle_ack mem_req", {31'd0, mem_req}, 32'd0);
            chk("idle_ack acks", {30'd0, i_ack, d_ack}, 32'd0);
            chk("idle_ack i_rdata", i_rdata, 32'h8888_8888);
            chk("idle_ack d_rdata", d_rdata, 32'h5000_0002);
        end
        mem_ack = 1'b0;

        // Reset in the second BUSY cycle of a fetch
        i_req = 1'b1;
        i_addr = 32'h0000_0600;
        @(negedge clk);
        chk("midrst busy1 mem_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        chk("midrst busy2 mem_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst i_ack", {31'd0, i_ack}, 32'd0);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst i_rdata", i_rdata, 32'd0);
        reset = 1'b0;
        run_vec(10, mk(0, 1, 0, 0, 0, 32'h0000_0600, 32'h0, 32'h0, 4'h0, 0,
                       32'h6666_6666, 0, 32'h0000_0600, 0, 32'h0, 4'hF, 0, 1, 32'h6666_6666));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
